// File: rtl/act_vec_driver.sv
// Streams VEC_LEN FP32 words from a source buffer through a start/done
// activation unit and writes each result to a destination buffer.
module act_vec_driver #(
  parameter int VEC_LEN = 16,
  parameter int AW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vec_start,
  output logic          o_vec_busy,
  output logic          o_vec_done,
  output logic [AW-1:0] o_in_rd_addr,
  input  logic [31:0]   i_in_rd_data,
  output logic          o_act_start,
  output logic [31:0]   o_act_in_fp,
  input  logic          i_act_done,
  input  logic [31:0]   i_act_out_fp,
  output logic          o_out_wr_en,
  output logic [AW-1:0] o_out_wr_addr,
  output logic [31:0]   o_out_wr_data,
  output logic          o_err_timeout
);

  localparam logic [AW-1:0] LAST_IDX = AW'(VEC_LEN - 1);
  localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_REQ     = 3'd3,
    S_RELEASE = 3'd4,
    S_WRITE   = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_cnt;
  logic [31:0]   r_result;
  logic [31:0]   r_act_in_fp;
  logic          r_act_start;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [31:0]   r_wr_data;
  logic          r_vec_done;
  logic          r_vec_busy;
  logic          r_err_timeout;

  // Sequencer: outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_cnt         <= 8'd0;
      r_result      <= 32'd0;
      r_act_in_fp   <= 32'd0;
      r_act_start   <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= 32'd0;
      r_vec_done    <= 1'b0;
      r_vec_busy    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_wr_en    <= 1'b0;
      r_vec_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_vec_start) begin
            r_state       <= S_FETCH;
            r_idx         <= '0;
            r_err_timeout <= 1'b0;
            r_vec_busy    <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_act_in_fp <= i_in_rd_data;
          r_cnt       <= 8'd0;
          r_act_start <= 1'b1;
          r_state     <= S_REQ;
        end
        // A done seen on the last allowed cycle still wins over the timeout.
        S_REQ: begin
          if (i_act_done) begin
            r_result    <= i_act_out_fp;
            r_act_start <= 1'b0;
            r_state     <= S_RELEASE;
          end else if (r_cnt == TO_LAST) begin
            r_result      <= QNAN;
            r_err_timeout <= 1'b1;
            r_act_start   <= 1'b0;
            r_state       <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RELEASE: begin
          if (!i_act_done) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_idx;
            r_wr_data <= r_result;
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_idx == LAST_IDX) begin
            r_vec_done <= 1'b1;
            r_state    <= S_FINISH;
          end else begin
            r_idx   <= r_idx + {{(AW-1){1'b0}}, 1'b1};
            r_state <= S_FETCH;
          end
        end
        S_FINISH: begin
          r_vec_busy <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_act_start <= 1'b0;
          r_vec_busy  <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_vec_busy    = r_vec_busy;
  assign o_vec_done    = r_vec_done;
  assign o_in_rd_addr  = r_idx;
  assign o_act_start   = r_act_start;
  assign o_act_in_fp   = r_act_in_fp;
  assign o_out_wr_en   = r_wr_en;
  assign o_out_wr_addr = r_wr_addr;
  assign o_out_wr_data = r_wr_data;
  assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_act_vec_driver.sv
// Directed bench for act_vec_driver: fixed-latency responder, source memory
// model and hand-computed write timing for each scenario.
module tb_act_vec_driver;
  localparam int VL = 4;
  localparam int AW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          vec_start;
  logic          vec_busy, vec_done, act_start, wr_en, err_timeout;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [31:0]   rd_data, act_in_fp, wr_data;
  logic          act_done = 1'b0;
  logic [31:0]   act_out_fp;
  logic [31:0]   src [0:255];

  act_vec_driver #(.VEC_LEN(VL), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_vec_start(vec_start),
    .o_vec_busy(vec_busy), .o_vec_done(vec_done),
    .o_in_rd_addr(rd_addr), .i_in_rd_data(rd_data),
    .o_act_start(act_start), .o_act_in_fp(act_in_fp),
    .i_act_done(act_done), .i_act_out_fp(act_out_fp),
    .o_out_wr_en(wr_en), .o_out_wr_addr(wr_addr), .o_out_wr_data(wr_data),
    .o_err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= src[rd_addr];

  // Responder: done rises after rise_dly start cycles, drops 2+hold_extra cycles after start falls.
  int rise_dly = 3, hold_extra = 0, hi_cnt = 0, lo_cnt = 0;
  bit stuck = 1'b0;
  assign act_out_fp = act_in_fp ^ 32'h8000_0000;
  always @(posedge clk) begin
    if (rst || stuck) begin
      act_done <= 1'b0; hi_cnt <= 0; lo_cnt <= 0;
    end else if (act_start) begin
      lo_cnt <= 0; hi_cnt <= hi_cnt + 1;
      if (hi_cnt >= rise_dly - 1) act_done <= 1'b1;
    end else begin
      hi_cnt <= 0; lo_cnt <= lo_cnt + 1;
      if (lo_cnt + 1 >= 2 + hold_extra) act_done <= 1'b0;
    end
  end

  int n_checks = 0, n_pass = 0;
  int rel;
  int wr_n, wr_cyc [0:15];
  logic [7:0]  wr_a [0:15];
  logic [31:0] wr_d [0:15];
  int done_n, done_cyc, busy_first, busy_last;
  int as_total, as_run, as_max, as_rises, viol_fp, viol_reas;
  logic prev_as, prev2_as, prev_hold;
  logic [31:0] prev_fp;
  logic [31:0] exp_xor [0:3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_log();
    wr_n = 0; done_n = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
    as_total = 0; as_run = 0; as_max = 0; as_rises = 0; viol_fp = 0; viol_reas = 0;
    prev_as = 1'b0; prev2_as = 1'b0; prev_hold = 1'b0; prev_fp = 32'd0;
  endtask

  task automatic step();
    @(negedge clk);
    rel++;
    if (wr_en) begin
      if (wr_n < 16) begin
        wr_cyc[wr_n] = rel; wr_a[wr_n] = wr_addr; wr_d[wr_n] = wr_data;
      end
      wr_n++;
    end
    if (vec_done) begin done_n++; done_cyc = rel; end
    if (vec_busy) begin
      if (busy_first < 0) busy_first = rel;
      busy_last = rel;
    end
    if (act_start) begin
      as_total++; as_run++;
      if (as_run > as_max) as_max = as_run;
      if (!prev_as) begin
        as_rises++;
        if (prev2_as || act_done) viol_reas++;
      end
    end else begin
      as_run = 0;
    end
    if (prev_hold && (act_start || act_done) && act_in_fp !== prev_fp) viol_fp++;
    prev_hold = act_start || act_done;
    prev_fp   = act_in_fp;
    prev2_as  = prev_as;
    prev_as   = act_start;
  endtask

  // Pulse vec_start in cycle 0 and run ncyc cycles; optional spurious start and reset.
  task automatic run_vec(input int ncyc, input int spur_at, input int rst_at);
    clear_log();
    rel = 0;
    vec_start = 1'b1;
    while (rel < ncyc) begin
      step();
      vec_start = (rel == spur_at);
      if (rel == 1) chk("err_clr_on_start", 32'(err_timeout), 32'd0);
      if (rel == rst_at) rst = 1'b1;
      if (rst_at >= 0 && rel == rst_at + 1) begin
        chk("rst_busy", 32'(vec_busy), 32'd0);
        chk("rst_act_start", 32'(act_start), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_done", 32'(vec_done), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_act_in_fp", act_in_fp, 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        rst = 1'b0;
      end
    end
  endtask

  task automatic check_run(input string tag, input int first, input int period, input bit qnan, input int exp_err);
    chk({tag, "_nwr"}, 32'(wr_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_wr_cyc"}, 32'(wr_cyc[i]), 32'(first + i * period));
      chk({tag, "_wr_addr"}, 32'(wr_a[i]), 32'(i));
      chk({tag, "_wr_data"}, wr_d[i], qnan ? 32'h7FC0_0000 : exp_xor[i]);
    end
    chk({tag, "_ndone"}, 32'(done_n), 32'd1);
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(first + 3 * period + 1));
    chk({tag, "_busy_first"}, 32'(busy_first), 32'd1);
    chk({tag, "_busy_last"}, 32'(busy_last), 32'(first + 3 * period + 1));
    chk({tag, "_err"}, 32'(err_timeout), 32'(exp_err));
    chk({tag, "_as_rises"}, 32'(as_rises), 32'd4);
    chk({tag, "_reassert"}, 32'(viol_reas), 32'd0);
    chk({tag, "_fp_stable"}, 32'(viol_fp), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) src[i] = 32'd0;
    src[0] = 32'h3F80_0000; src[1] = 32'hBF80_0000; src[2] = 32'h0000_0000; src[3] = 32'h4000_0000;
    exp_xor[0] = 32'hBF80_0000; exp_xor[1] = 32'h3F80_0000;
    exp_xor[2] = 32'h8000_0000; exp_xor[3] = 32'hC000_0000;
    rst = 1'b1; vec_start = 1'b0; rel = 0;
    clear_log();
    repeat (3) step();
    chk("init_busy", 32'(vec_busy), 32'd0);
    chk("init_act_start", 32'(act_start), 32'd0);
    chk("init_wr_en", 32'(wr_en), 32'd0);
    chk("init_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // Nominal: element period 10 (FETCH, LOAD, 4x REQ, 3x RELEASE, WRITE).
    run_vec(45, -10, -10);
    check_run("nominal", 10, 10, 1'b0, 0);

    // Start pulse at cycle 5 while busy is ignored.
    run_vec(45, 5, -10);
    check_run("spur_start", 10, 10, 1'b0, 0);

    // Done held 4 extra cycles: RELEASE stretches to 7, period 14.
    hold_extra = 4;
    run_vec(62, -10, -10);
    check_run("long_done", 14, 14, 1'b0, 0);
    hold_extra = 0;

    // Done arrives on the 15th REQ cycle: result kept, no error; period 21.
    rise_dly = 14;
    run_vec(90, -10, -10);
    check_run("late_done", 21, 21, 1'b0, 0);
    rise_dly = 3;

    // Stuck responder: 15 REQ cycles, 1 RELEASE, qNaN written; period 19.
    stuck = 1'b1;
    run_vec(82, -10, -10);
    check_run("timeout", 19, 19, 1'b1, 1);
    chk("timeout_as_max", 32'(as_max), 32'd15);
    chk("timeout_as_total", 32'(as_total), 32'd60);
    stuck = 1'b0;
    repeat (3) step();

    // Reset in cycle 15 aborts after the first write.
    run_vec(20, -10, 15);
    chk("abort_nwr", 32'(wr_n), 32'd1);
    chk("abort_wr_cyc", 32'(wr_cyc[0]), 32'd10);
    chk("abort_wr_data", wr_d[0], 32'hBF80_0000);
    chk("abort_ndone", 32'(done_n), 32'd0);
    repeat (3) step();
    run_vec(45, -10, -10);
    check_run("restart", 10, 10, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
